// File: rtl/frame_info_sequencer_if.sv
// Frame stream in / segmented command + image streams out for frame_info_sequencer.
interface frame_info_sequencer_if #(
  parameter int unsigned GEV_DE_WD   = 2,
  parameter int unsigned GEV_DATA_WD = 64
);
  logic                   i_stream_enable;
  logic                   i_fval;
  logic [GEV_DE_WD-1:0]   iv_dval;
  logic [GEV_DATA_WD-1:0] iv_data;
  logic                   o_info_flag;
  logic                   o_statis_flag;
  logic [GEV_DE_WD-1:0]   ov_cmd_dval;
  logic [GEV_DATA_WD-1:0] ov_cmd_data;
  logic                   o_img_fval;
  logic [GEV_DE_WD-1:0]   ov_img_dval;
  logic [GEV_DATA_WD-1:0] ov_img_data;
  logic                   o_frame_done;
  logic                   o_frame_err;
  logic [1:0]             ov_err_code;
  logic [15:0]            ov_frame_cnt;

  modport master (
    output i_stream_enable, i_fval, iv_dval, iv_data,
    input  o_info_flag, o_statis_flag, ov_cmd_dval, ov_cmd_data, o_img_fval,
           ov_img_dval, ov_img_data, o_frame_done, o_frame_err, ov_err_code, ov_frame_cnt
  );

  modport slave (
    input  i_stream_enable, i_fval, iv_dval, iv_data,
    output o_info_flag, o_statis_flag, ov_cmd_dval, ov_cmd_data, o_img_fval,
           ov_img_dval, ov_img_data, o_frame_done, o_frame_err, ov_err_code, ov_frame_cnt
  );
endinterface

// File: rtl/frame_info_sequencer.sv
// Splits each frame into info / image / statis segments; info and statis go to the
// command port with segment flags, image beats to the image port.
module frame_info_sequencer #(
  parameter int unsigned INFO_SIZE   = 256,
  parameter int unsigned STATIS_SIZE = 256,
  parameter int unsigned GEV_DE_WD   = 2,
  parameter int unsigned GEV_DATA_WD = 64
) (
  input logic clk,
  input logic reset,
  frame_info_sequencer_if.slave bus
);
  localparam int unsigned INFO_BEATS   = INFO_SIZE / 8;
  localparam int unsigned STATIS_BEATS = STATIS_SIZE / 8;
  localparam int unsigned CNT_W        = 30;

  typedef enum logic [2:0] {S_IDLE, S_INFO, S_IMAGE, S_STATIS, S_TAIL, S_SKIP} state_t;

  state_t                 state_q, state_d, eff;
  logic [CNT_W-1:0]       cnt_q, cnt_d, img_last;
  logic [31:0]            payload_q, payload_d, pl_cur;
  logic [32:0]            pl_up;
  logic                   fval_q, tail_err_q, tail_err_d, beat;
  logic                   info_flag_q, info_flag_d, statis_flag_q, statis_flag_d;
  logic                   img_fval_q, img_fval_d, done_q, done_d, err_q, err_d;
  logic [GEV_DE_WD-1:0]   cmd_dval_q, cmd_dval_d, img_dval_q, img_dval_d;
  logic [GEV_DATA_WD-1:0] cmd_data_q, cmd_data_d, img_data_q, img_data_d;
  logic [1:0]             err_code_q, err_code_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;

  // Next-state and registered-output values
  always_comb begin
    beat   = bus.iv_dval[0];
    eff    = state_q;
    if (state_q == S_IDLE && bus.i_fval && !fval_q && bus.i_stream_enable) eff = S_INFO;
    // payload_size may be latched on the very beat that closes the info segment
    pl_cur = payload_q;
    if (eff == S_INFO && beat && cnt_q == CNT_W'(5)) pl_cur = bus.iv_data[63:32];
    pl_up    = 33'(pl_cur) + 33'd7;
    img_last = CNT_W'(pl_up[32:3]) - CNT_W'(1);

    state_d       = eff;
    cnt_d         = cnt_q;
    payload_d     = payload_q;
    tail_err_d    = tail_err_q;
    info_flag_d   = 1'b0;
    statis_flag_d = 1'b0;
    img_fval_d    = 1'b0;
    cmd_dval_d    = '0;
    img_dval_d    = '0;
    cmd_data_d    = cmd_data_q;
    img_data_d    = img_data_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    err_code_d    = err_code_q;
    frame_cnt_d   = frame_cnt_q;

    unique case (eff)
      S_IDLE: begin
        cnt_d = '0;
        // level-high fval without a seen-low edge (e.g. after reset) or disabled stream
        if (bus.i_fval) state_d = S_SKIP;
      end
      S_INFO, S_IMAGE, S_STATIS: begin
        if (!bus.i_fval) begin
          err_d      = 1'b1;
          err_code_d = 2'b01;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end else begin
          info_flag_d   = (eff == S_INFO)   && (info_flag_q   || beat);
          statis_flag_d = (eff == S_STATIS) && (statis_flag_q || beat);
          img_fval_d    = (eff == S_IMAGE)  && (img_fval_q    || beat);
          if (beat) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (eff == S_IMAGE) begin
              img_dval_d = bus.iv_dval;
              img_data_d = bus.iv_data;
            end else begin
              cmd_dval_d = bus.iv_dval;
              cmd_data_d = bus.iv_data;
            end
            if (eff == S_INFO) begin
              payload_d = pl_cur;
              if (cnt_q == CNT_W'(INFO_BEATS - 1)) begin
                cnt_d   = '0;
                state_d = (pl_cur == 32'd0) ? S_STATIS : S_IMAGE;
              end
            end else if (eff == S_IMAGE) begin
              if (cnt_q == img_last) begin
                cnt_d   = '0;
                state_d = S_STATIS;
                if (pl_cur[2:0] != 3'd0 && pl_cur[2:0] <= 3'd4) img_dval_d = GEV_DE_WD'(1);
                else img_dval_d = '1;
              end
            end else if (cnt_q == CNT_W'(STATIS_BEATS - 1)) begin
              cnt_d       = '0;
              done_d      = 1'b1;
              frame_cnt_d = frame_cnt_q + 16'd1;
              tail_err_d  = 1'b0;
              state_d     = S_TAIL;
            end
          end
        end
      end
      S_TAIL: begin
        if (!bus.i_fval) state_d = S_IDLE;
        else if (beat && !tail_err_q) begin
          err_d      = 1'b1;
          err_code_d = 2'b10;
          tail_err_d = 1'b1;
        end
      end
      S_SKIP: if (!bus.i_fval) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; fval history resets high so a frame in flight is skipped
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      payload_q     <= '0;
      fval_q        <= 1'b1;
      tail_err_q    <= 1'b0;
      info_flag_q   <= 1'b0;
      statis_flag_q <= 1'b0;
      img_fval_q    <= 1'b0;
      cmd_dval_q    <= '0;
      img_dval_q    <= '0;
      cmd_data_q    <= '0;
      img_data_q    <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= 2'b00;
      frame_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      payload_q     <= payload_d;
      fval_q        <= bus.i_fval;
      tail_err_q    <= tail_err_d;
      info_flag_q   <= info_flag_d;
      statis_flag_q <= statis_flag_d;
      img_fval_q    <= img_fval_d;
      cmd_dval_q    <= cmd_dval_d;
      img_dval_q    <= img_dval_d;
      cmd_data_q    <= cmd_data_d;
      img_data_q    <= img_data_d;
      done_q        <= done_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign bus.o_info_flag   = info_flag_q;
  assign bus.o_statis_flag = statis_flag_q;
  assign bus.ov_cmd_dval   = cmd_dval_q;
  assign bus.ov_cmd_data   = cmd_data_q;
  assign bus.o_img_fval    = img_fval_q;
  assign bus.ov_img_dval   = img_dval_q;
  assign bus.ov_img_data   = img_data_q;
  assign bus.o_frame_done  = done_q;
  assign bus.o_frame_err   = err_q;
  assign bus.ov_err_code   = err_code_q;
  assign bus.ov_frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_frame_info_sequencer.sv
// Scoreboard bench for frame_info_sequencer: directed frames push expected beats/pulses,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_frame_info_sequencer;
  localparam int INFO_BEATS   = 32;
  localparam int STATIS_BEATS = 32;
  localparam logic [2:0] K_INFO = 3'd0, K_STAT = 3'd1, K_IMG = 3'd2, K_DONE = 3'd3, K_ERR = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [1:0]  dval;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_info_sequencer_if #(.GEV_DE_WD(2), .GEV_DATA_WD(64)) bus();
  frame_info_sequencer #(.INFO_SIZE(256), .STATIS_SIZE(256), .GEV_DE_WD(2), .GEV_DATA_WD(64))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  int exp_cnt = 0;
  int info_hi, img_hi, stat_hi, info_rise, img_rise, stat_rise;
  logic p_info = 1'b0, p_img = 1'b0, p_stat = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pop_cmp(input logic [2:0] kind, input logic [1:0] dv, input logic [63:0] d,
                         input string name);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s actual kind=%0d data=%0h required none", name, kind, d);
    end else begin
      e = q.pop_front();
      chk({name, "_kind"}, 64'(kind), 64'(e.kind));
      chk({name, "_dval"}, 64'(dv), 64'(e.dval));
      chk({name, "_data"}, d, e.data);
    end
  endtask

  // Monitor: compares every presented beat/pulse against the scoreboard
  always @(negedge clk) begin
    if (bus.ov_cmd_dval != 2'b00) begin
      chk("cmd_one_flag", 64'(bus.o_info_flag ^ bus.o_statis_flag), 64'd1);
      pop_cmp(bus.o_info_flag ? K_INFO : K_STAT, bus.ov_cmd_dval, bus.ov_cmd_data, "cmd");
    end
    if (bus.ov_img_dval != 2'b00) begin
      chk("img_fval_with_beat", 64'(bus.o_img_fval), 64'd1);
      pop_cmp(K_IMG, bus.ov_img_dval, bus.ov_img_data, "img");
    end
    if (bus.o_frame_done) begin
      chk("done_with_last_statis", 64'(bus.ov_cmd_dval[0] & bus.o_statis_flag), 64'd1);
      pop_cmp(K_DONE, 2'b00, 64'(bus.ov_frame_cnt), "done");
    end
    if (bus.o_frame_err) pop_cmp(K_ERR, 2'b00, 64'(bus.ov_err_code), "err");
    if (bus.o_info_flag | bus.o_img_fval | bus.o_statis_flag)
      chk("flags_exclusive", 64'($countones({bus.o_info_flag, bus.o_img_fval, bus.o_statis_flag})), 64'd1);
    info_hi   += int'(bus.o_info_flag);
    img_hi    += int'(bus.o_img_fval);
    stat_hi   += int'(bus.o_statis_flag);
    info_rise += int'(bus.o_info_flag & ~p_info);
    img_rise  += int'(bus.o_img_fval & ~p_img);
    stat_rise += int'(bus.o_statis_flag & ~p_stat);
    p_info = bus.o_info_flag;
    p_img  = bus.o_img_fval;
    p_stat = bus.o_statis_flag;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.iv_dval = 2'b00;
    repeat (n) tick();
  endtask

  task automatic clr_stats();
    info_hi = 0; img_hi = 0; stat_hi = 0; info_rise = 0; img_rise = 0; stat_rise = 0;
  endtask

  task automatic send(input logic [63:0] d, input logic [1:0] dv, input int gap,
                      input bit push, input exp_t e);
    while (gap > 0 && $urandom_range(99) < gap) begin
      bus.iv_dval = 2'b00;
      bus.iv_data = {$urandom, $urandom};
      tick();
    end
    bus.iv_dval = dv;
    bus.iv_data = d;
    if (push) q.push_back(e);
    tick();
    bus.iv_dval = 2'b00;
  endtask

  // One frame: info (payload at beat 5), image, statis, optional extra beats / truncation
  task automatic frame(input logic [31:0] pl, input bit en, input int gap, input int extra,
                       input int trunc);
    int nimg;
    logic [63:0] d;
    logic [1:0]  dv, edv;
    nimg = int'((33'(pl) + 33'd7) >> 3);
    bus.i_stream_enable = en;
    bus.i_fval = 1'b1;
    idle(1);
    for (int i = 0; i < INFO_BEATS; i++) begin
      d  = (i == 5) ? {pl, 32'h0000_0005} : {32'hA1F0_0000 | 32'(i), 32'(i) ^ 32'h5A5A_0000};
      dv = {1'($urandom_range(1)), 1'b1};
      send(d, dv, gap, en, '{kind: K_INFO, dval: dv, data: d});
    end
    for (int i = 0; i < nimg; i++) begin
      if (i == trunc) begin
        bus.i_fval = 1'b0;
        q.push_back('{kind: K_ERR, dval: 2'b00, data: 64'd1});
        idle(4);
        return;
      end
      d   = {32'hB2E0_0000 | 32'(i), pl};
      dv  = (i == nimg - 1) ? 2'b11 : {1'($urandom_range(1)), 1'b1};
      edv = (i == nimg - 1 && pl[2:0] >= 3'd1 && pl[2:0] <= 3'd4) ? 2'b01 : dv;
      send(d, dv, gap, en, '{kind: K_IMG, dval: edv, data: d});
    end
    for (int i = 0; i < STATIS_BEATS; i++) begin
      d  = {32'hC3D0_0000 | 32'(i), ~32'(i)};
      dv = {1'($urandom_range(1)), 1'b1};
      send(d, dv, gap, en, '{kind: K_STAT, dval: dv, data: d});
      if (en && i == STATIS_BEATS - 1) begin
        exp_cnt = (exp_cnt + 1) % 65536;
        q.push_back('{kind: K_DONE, dval: 2'b00, data: 64'(exp_cnt)});
      end
    end
    for (int i = 0; i < extra; i++)
      send({$urandom, $urandom}, 2'b11, 0, en && i == 0, '{kind: K_ERR, dval: 2'b00, data: 64'd2});
    bus.i_fval = 1'b0;
    idle(4);
  endtask

  initial begin
    bus.i_stream_enable = 1'b0;
    bus.i_fval = 1'b0;
    bus.iv_dval = 2'b00;
    bus.iv_data = 64'd0;
    clr_stats();
    idle(3);
    chk("rst_cmd_dval", 64'(bus.ov_cmd_dval), 64'd0);
    chk("rst_img_dval", 64'(bus.ov_img_dval), 64'd0);
    chk("rst_flags", 64'({bus.o_info_flag, bus.o_statis_flag, bus.o_img_fval}), 64'd0);
    chk("rst_pulses", 64'({bus.o_frame_done, bus.o_frame_err}), 64'd0);
    chk("rst_data", bus.ov_cmd_data | bus.ov_img_data, 64'd0);
    chk("rst_err_code", 64'(bus.ov_err_code), 64'd0);
    chk("rst_frame_cnt", 64'(bus.ov_frame_cnt), 64'd0);
    reset = 1'b0;
    idle(2);

    // Continuous 64-byte payload frame
    clr_stats();
    frame(32'd64, 1'b1, 0, 0, -1);
    chk("t1_info_hi", 64'(info_hi), 64'd32);
    chk("t1_img_hi", 64'(img_hi), 64'd8);
    chk("t1_stat_hi", 64'(stat_hi), 64'd32);
    chk("t1_frame_cnt", 64'(bus.ov_frame_cnt), 64'd1);

    // Partial last-beat payloads
    frame(32'd13, 1'b1, 0, 0, -1);
    frame(32'd12, 1'b1, 0, 0, -1);

    // Zero payload: statis follows info with no image segment
    clr_stats();
    frame(32'd0, 1'b1, 0, 0, -1);
    chk("t3_img_rise", 64'(img_rise), 64'd0);
    chk("t3_info_stat_rise", 64'({info_rise[7:0], stat_rise[7:0]}), 64'h0101);
    chk("t3_frame_cnt", 64'(bus.ov_frame_cnt), 64'(exp_cnt));

    // Truncation after 3 image beats
    clr_stats();
    frame(32'd64, 1'b1, 0, 0, 3);
    chk("t4_err_code", 64'(bus.ov_err_code), 64'd1);
    chk("t4_frame_cnt", 64'(bus.ov_frame_cnt), 64'(exp_cnt));
    chk("t4_flags_low", 64'({bus.o_info_flag, bus.o_statis_flag, bus.o_img_fval}), 64'd0);

    // Overrun tail, then a disabled frame
    frame(32'd16, 1'b1, 0, 2, -1);
    chk("t5_err_code", 64'(bus.ov_err_code), 64'd2);
    clr_stats();
    frame(32'd16, 1'b0, 0, 0, -1);
    chk("t5_skip_rises", 64'(info_rise + img_rise + stat_rise), 64'd0);
    chk("t5_skip_cnt", 64'(bus.ov_frame_cnt), 64'(exp_cnt));

    // Random 50% dval gaps over three frames
    clr_stats();
    frame(32'd40, 1'b1, 50, 0, -1);
    frame(32'd1, 1'b1, 50, 0, -1);
    frame(32'd20, 1'b1, 50, 0, -1);
    chk("t6_rises", 64'({info_rise[7:0], img_rise[7:0], stat_rise[7:0]}), 64'h030303);
    chk("t6_frame_cnt", 64'(bus.ov_frame_cnt), 64'(exp_cnt));

    // Reset mid-info: outputs clear, remainder of frame skipped
    bus.i_stream_enable = 1'b1;
    bus.i_fval = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++)
      send(64'hD000_0000 + 64'(i), 2'b11, 0, 1'b1, '{kind: K_INFO, dval: 2'b11, data: 64'hD000_0000 + 64'(i)});
    reset = 1'b1;
    bus.iv_dval = 2'b11;
    tick();
    reset = 1'b0;
    bus.iv_dval = 2'b00;
    chk("t7_rst_dval", 64'({bus.ov_cmd_dval, bus.ov_img_dval}), 64'd0);
    chk("t7_rst_flags", 64'({bus.o_info_flag, bus.o_statis_flag, bus.o_img_fval}), 64'd0);
    chk("t7_rst_cnt", 64'(bus.ov_frame_cnt), 64'd0);
    exp_cnt = 0;
    for (int i = 4; i < 40; i++) send(64'hE000_0000 + 64'(i), 2'b11, 0, 1'b0, '0);
    bus.i_fval = 1'b0;
    idle(4);
    frame(32'd8, 1'b1, 0, 0, -1);
    chk("t7_recover_cnt", 64'(bus.ov_frame_cnt), 64'd1);

    idle(5);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
